bcd_sub_seq: RTL and testbench

//  Digit-serial signed 3-digit BCD subtractor; computes R = A - B on sign-magnitude BCD operands.

---
 rtl/bcd_sub_seq.sv | 187 ++++++++++++++++++
 tb/tb_bcd_sub_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_sub_seq.sv
// Digit-serial signed BCD subtractor: R = A - B on sign-magnitude operands.
// One BCD digit is processed per clock, least significant digit first.
// Operands with opposite signs are added as magnitudes. Operands with equal
// signs are subtracted as magnitudes. A final borrow means |A| < |B|; a
// tens-complement pass then turns the wrapped difference into |B| - |A|.
module bcd_sub_seq #(
  parameter int NDIG = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              a_sign,
  input  logic [4*NDIG-1:0] a_bcd,
  input  logic              b_sign,
  input  logic [4*NDIG-1:0] b_bcd,
  output logic              busy,
  output logic              done,
  output logic              r_sign,
  output logic [4*NDIG-1:0] r_bcd,
  output logic              ovf,
  output logic              err
);

  localparam int W  = 4 * NDIG;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // One corrected digit step; returns {carry_or_borrow, digit}.
  // The add path is biased by -10 so that both directions stay within a
  // 5-bit signed range (-10..9). A negative value gets +10 applied. On the
  // add path a negative value means no carry; on the subtract path it means
  // a borrow.
  function automatic logic [4:0] digit_step(input logic [3:0] a, input logic [3:0] b,
                                            input logic ci, input logic add);
    logic signed [4:0] s;
    logic signed [4:0] t;
    logic              neg;
    logic              co;
    if (add) s = $signed({1'b0, a}) + $signed({1'b0, b}) + $signed({4'b0, ci}) - 5'sd10;
    else     s = $signed({1'b0, a}) - $signed({1'b0, b}) - $signed({4'b0, ci});
    neg = (s < 5'sd0);
    t   = neg ? (s + 5'sd10) : s;
    co  = add ? ~neg : neg;
    return {co, t[3:0]};
  endfunction

  // Flags any digit above 9.
  function automatic logic any_bad(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  state_t         r_state;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_work;
  logic           r_a_sign;
  logic           r_add;
  logic           r_cb;
  logic [IW-1:0]  r_idx;
  logic           r_busy;
  logic           r_done;
  logic           r_res_sign;
  logic [W-1:0]   r_res_bcd;
  logic           r_ovf;
  logic           r_err;

  logic [4:0]     w_step;
  logic [W-1:0]   w_work_nx;
  logic           w_nz;
  logic           w_bad;
  logic           w_last;

  // Digit datapath: CALC consumes operand digits, FIX complements the stored raw difference.
  always_comb begin
    w_step = 5'd0;
    if (r_state == S_FIX) w_step = digit_step(4'd0, r_work[3:0], r_cb, 1'b0);
    else                  w_step = digit_step(r_a[3:0], r_b[3:0], r_cb, r_add);
  end

  assign w_work_nx = {w_step[3:0], r_work[W-1:4]};
  assign w_nz      = |w_work_nx;
  assign w_bad     = any_bad(a_bcd) | any_bad(b_bcd);
  assign w_last    = (r_idx == LAST_IDX);

  // Control FSM with registered outputs; results are written only once they are complete and corrected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_work     <= '0;
      r_a_sign   <= 1'b0;
      r_add      <= 1'b0;
      r_cb       <= 1'b0;
      r_idx      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_res_sign <= 1'b0;
      r_res_bcd  <= '0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a        <= a_bcd;
            r_b        <= b_bcd;
            r_a_sign   <= a_sign;
            r_add      <= a_sign ^ b_sign;
            r_work     <= '0;
            r_cb       <= 1'b0;
            r_idx      <= '0;
            r_busy     <= 1'b1;
            r_ovf      <= 1'b0;
            r_err      <= 1'b0;
            r_res_bcd  <= '0;
            r_res_sign <= 1'b0;
            r_state    <= w_bad ? S_ERR : S_CALC;
          end
        end
        S_ERR: begin
          r_err      <= 1'b1;
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_res_bcd  <= '0;
          r_res_sign <= 1'b0;
          r_state    <= S_IDLE;
        end
        S_CALC: begin
          r_work <= w_work_nx;
          r_a    <= {4'd0, r_a[W-1:4]};
          r_b    <= {4'd0, r_b[W-1:4]};
          r_cb   <= w_step[4];
          r_idx  <= r_idx + 1'b1;
          if (w_last) begin
            if (r_add || !w_step[4]) begin
              r_ovf      <= r_add & w_step[4];
              r_res_bcd  <= w_work_nx;
              r_res_sign <= r_a_sign & w_nz;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_idx   <= '0;
              r_cb    <= 1'b0;
              r_state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          r_work <= w_work_nx;
          r_cb   <= w_step[4];
          r_idx  <= r_idx + 1'b1;
          if (w_last) begin
            r_res_bcd  <= w_work_nx;
            r_res_sign <= ~r_a_sign & w_nz;
            r_done     <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign r_sign = r_res_sign;
  assign r_bcd  = r_res_bcd;
  assign ovf    = r_ovf;
  assign err    = r_err;

endmodule

// File: tb/tb_bcd_sub_seq.sv
// Directed bench for bcd_sub_seq with hand-computed expected results.
module tb_bcd_sub_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        a_sign;
  logic [11:0] a_bcd;
  logic        b_sign;
  logic [11:0] b_bcd;
  logic        busy;
  logic        done;
  logic        r_sign;
  logic [11:0] r_bcd;
  logic        ovf;
  logic        err;

  int total;
  int bad;

  bcd_sub_seq #(.NDIG(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_sign(a_sign), .a_bcd(a_bcd), .b_sign(b_sign), .b_bcd(b_bcd),
    .busy(busy), .done(done), .r_sign(r_sign), .r_bcd(r_bcd),
    .ovf(ovf), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Starts one operation and returns the cycle count from the accept edge to done (-1 on timeout).
  task automatic run_op(input logic as, input logic [11:0] a, input logic bs,
                        input logic [11:0] b, output int lat);
    @(negedge clk);
    a_sign = as; a_bcd = a; b_sign = bs; b_bcd = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    a_sign = 1'b0; a_bcd = '0; b_sign = 1'b0; b_bcd = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy, done, r_sign, r_bcd, ovf, err} !== 17'd0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", {busy, done, r_sign, r_bcd, ovf, err});
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_sub_pos();
    int lat;
    run_op(1'b0, 12'h123, 1'b0, 12'h045, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL sub_pos_latency got=%0d want=3", lat); end
    total++; if ({r_sign, r_bcd} !== {1'b0, 12'h078}) begin
      bad++; $display("FAIL sub_pos_result got=%b/%h want=0/078", r_sign, r_bcd); end
    total++; if ({ovf, err, busy} !== 3'b000) begin
      bad++; $display("FAIL sub_pos_flags got=%b want=000", {ovf, err, busy}); end
  endtask

  task automatic test_fix();
    int lat;
    run_op(1'b0, 12'h045, 1'b0, 12'h123, lat);
    total++; if (lat !== 6) begin bad++; $display("FAIL fix_latency got=%0d want=6", lat); end
    total++; if ({r_sign, r_bcd} !== {1'b1, 12'h078}) begin
      bad++; $display("FAIL fix_result got=%b/%h want=1/078", r_sign, r_bcd); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL fix_ovf got=%b want=0", ovf); end
  endtask

  task automatic test_add_ovf();
    int lat;
    run_op(1'b0, 12'h500, 1'b1, 12'h600, lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL add_latency got=%0d want=3", lat); end
    total++; if ({r_sign, r_bcd, ovf} !== {1'b0, 12'h100, 1'b1}) begin
      bad++; $display("FAIL add_ovf got=%b/%h/%b want=0/100/1", r_sign, r_bcd, ovf); end
    run_op(1'b1, 12'h250, 1'b0, 12'h250, lat);
    total++; if ({r_sign, r_bcd, ovf} !== {1'b1, 12'h500, 1'b0}) begin
      bad++; $display("FAIL add_neg got=%b/%h/%b want=1/500/0", r_sign, r_bcd, ovf); end
  endtask

  task automatic test_zero_max();
    int lat;
    run_op(1'b1, 12'h250, 1'b1, 12'h250, lat);
    total++; if ({r_sign, r_bcd} !== {1'b0, 12'h000}) begin
      bad++; $display("FAIL zero_sign got=%b/%h want=0/000", r_sign, r_bcd); end
    total++; if (lat !== 3) begin bad++; $display("FAIL zero_latency got=%0d want=3", lat); end
    run_op(1'b0, 12'h999, 1'b0, 12'h000, lat);
    total++; if ({r_sign, r_bcd, ovf} !== {1'b0, 12'h999, 1'b0}) begin
      bad++; $display("FAIL max_result got=%b/%h/%b want=0/999/0", r_sign, r_bcd, ovf); end
  endtask

  task automatic test_err();
    int lat;
    run_op(1'b0, 12'h1A3, 1'b0, 12'h001, lat);
    total++; if (lat !== 1) begin bad++; $display("FAIL err_latency got=%0d want=1", lat); end
    total++; if ({err, r_sign, r_bcd, busy} !== {1'b1, 1'b0, 12'h000, 1'b0}) begin
      bad++; $display("FAIL err_result got=%b/%b/%h/%b want=1/0/000/0", err, r_sign, r_bcd, busy); end
    // A valid operation clears err at its own accept edge.
    @(negedge clk);
    a_sign = 1'b0; a_bcd = 12'h321; b_sign = 1'b0; b_bcd = 12'h021; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if ({err, busy} !== 2'b01) begin
      bad++; $display("FAIL err_clear got=%b want=01", {err, busy}); end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    total++; if ({lat == 3, r_sign, r_bcd} !== {1'b1, 1'b0, 12'h300}) begin
      bad++; $display("FAIL err_next_op got=%0d/%b/%h want=3/0/300", lat, r_sign, r_bcd); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    int dones;
    @(negedge clk);
    a_sign = 1'b0; a_bcd = 12'h123; b_sign = 1'b0; b_bcd = 12'h045; start = 1'b1;
    @(negedge clk);
    a_sign = 1'b1; a_bcd = 12'h999; b_sign = 1'b0; b_bcd = 12'h001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    total++; if ({lat != -1, r_sign, r_bcd, ovf} !== {1'b1, 1'b0, 12'h078, 1'b0}) begin
      bad++; $display("FAIL busy_ignore got=%0d/%b/%h/%b want=done/0/078/0", lat, r_sign, r_bcd, ovf); end
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    total++; if (dones !== 0) begin
      bad++; $display("FAIL busy_no_second_done got=%0d want=0", dones); end
    total++; if (r_bcd !== 12'h078) begin
      bad++; $display("FAIL busy_hold got=%h want=078", r_bcd); end
  endtask

  task automatic test_reset_mid_fix();
    int dones;
    @(negedge clk);
    a_sign = 1'b0; a_bcd = 12'h045; b_sign = 1'b0; b_bcd = 12'h123; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if ({busy, done, r_sign, r_bcd, ovf, err} !== 17'd0) begin
      bad++; $display("FAIL reset_mid_fix got=%h want=0", {busy, done, r_sign, r_bcd, ovf, err}); end
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    total++; if (dones !== 0) begin
      bad++; $display("FAIL reset_no_done got=%0d want=0", dones); end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(1'b0, 12'h123, 1'b0, 12'h045, lat);
    total++; if ({lat, r_bcd} !== {32'sd3, 12'h078}) begin
      bad++; $display("FAIL b2b_first got=%0d/%h want=3/078", lat, r_bcd); end
    // Still inside the done cycle: request the next operation right away.
    a_sign = 1'b1; a_bcd = 12'h250; b_sign = 1'b0; b_bcd = 12'h250; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if ({done, busy} !== 2'b01) begin
      bad++; $display("FAIL b2b_accept got=%b want=01", {done, busy}); end
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    total++; if ({lat == 3, r_sign, r_bcd, ovf} !== {1'b1, 1'b1, 12'h500, 1'b0}) begin
      bad++; $display("FAIL b2b_second got=%0d/%b/%h/%b want=3/1/500/0", lat, r_sign, r_bcd, ovf); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin
      bad++; $display("FAIL b2b_done_width got=%b want=0", done); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_sub_pos();
    test_fix();
    test_add_ovf();
    test_zero_max();
    test_err();
    test_busy_ignore();
    test_reset_mid_fix();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
